// File: rtl/mole_pkg.sv
// Shared types and constants for the mole spawn scheduler and its LFSR.
package mole_pkg;

  localparam logic [1:0] MOLE_EMPTY = 2'b00;
  localparam logic [1:0] MOLE_DEEP  = 2'b01;
  localparam logic [1:0] MOLE_UP    = 2'b10;
  localparam logic [1:0] MOLE_HIT   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PICK,
    ST_ISSUE,
    ST_DONE
  } sched_state_t;

  // x^8 + x^6 + x^5 + x^4 + 1 taps on q[7], q[5], q[4], q[3]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_lfsr8.sv
// 8-bit Fibonacci LFSR used for pseudo-random hole selection.
module mole_lfsr8
  import mole_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Spawn scheduler: picks idle holes, drives one-hot start requests and runs the round timer.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int unsigned N_MOLES     = 4,
  parameter int unsigned MAX_ACTIVE  = 2,
  parameter int unsigned SPAWN_GAP   = 6,
  parameter int unsigned START_HOLD  = 10,
  parameter int unsigned GAME_FRAMES = 1800,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                   animation_clk,
  input  logic                   rst,
  input  logic                   run_en,
  input  logic                   pause,
  input  logic [2*N_MOLES-1:0]   mole_state,
  output logic [N_MOLES-1:0]     start,
  output logic                   game_over,
  output logic [15:0]            frames_left,
  output logic [3:0]             active_count,
  output logic [7:0]             spawn_count
);

  localparam int unsigned SEL_W = $clog2(N_MOLES);
  localparam logic [3:0]  MAX_ACT     = 4'(MAX_ACTIVE);
  localparam logic [7:0]  GAP_INIT    = 8'(SPAWN_GAP);
  localparam logic [7:0]  HOLD_LAST   = 8'(START_HOLD - 1);
  localparam logic [15:0] FRAMES_INIT = 16'(GAME_FRAMES);

  sched_state_t     state, state_d;
  logic [7:0]       gap_cnt, gap_d;
  logic [7:0]       hold_cnt, hold_d;
  logic [SEL_W-1:0] sel, sel_d;
  logic [15:0]      frames_d;
  logic [7:0]       spawn_d;
  logic [7:0]       lfsr;
  logic             lfsr_unused;
  logic [N_MOLES-1:0] idle;
  logic [3:0]       busy_cnt;

  mole_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (animation_clk),
    .rst (rst),
    .en  (!pause),
    .q   (lfsr)
  );

  assign lfsr_unused = ^lfsr[7:SEL_W];

  // First idle hole at or after the candidate, wrapping around the array.
  function automatic logic [SEL_W-1:0] next_idle(input logic [SEL_W-1:0] c,
                                                 input logic [N_MOLES-1:0] idle_v);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    logic             found;
    pick  = c;
    found = 1'b0;
    for (int unsigned k = 0; k < N_MOLES; k++) begin
      idx = c + SEL_W'(k);
      if (!found && idle_v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    idle     = '0;
    busy_cnt = '0;
    for (int unsigned i = 0; i < N_MOLES; i++) begin
      idle[i] = (mole_state[2*i +: 2] == MOLE_EMPTY);
      if (!idle[i]) busy_cnt = busy_cnt + 4'd1;
    end
  end

  always_ff @(posedge animation_clk or posedge rst) begin
    if (rst) active_count <= '0;
    else     active_count <= busy_cnt;
  end

  always_ff @(posedge animation_clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      gap_cnt     <= '0;
      hold_cnt    <= '0;
      sel         <= '0;
      frames_left <= FRAMES_INIT;
      spawn_count <= '0;
    end else if (!pause) begin
      state       <= state_d;
      gap_cnt     <= gap_d;
      hold_cnt    <= hold_d;
      sel         <= sel_d;
      frames_left <= frames_d;
      spawn_count <= spawn_d;
    end
  end

  always_comb begin
    state_d  = state;
    gap_d    = gap_cnt;
    hold_d   = hold_cnt;
    sel_d    = sel;
    frames_d = frames_left;
    spawn_d  = spawn_count;
    case (state)
      ST_IDLE: begin
        if (run_en) begin
          state_d  = ST_WAIT;
          frames_d = FRAMES_INIT;
          gap_d    = GAP_INIT;
          spawn_d  = '0;
        end
      end
      ST_WAIT, ST_PICK, ST_ISSUE: begin
        // Abort beats expiry, and expiry beats any spawn activity on the same edge.
        if (!run_en) begin
          state_d = ST_IDLE;
        end else if (frames_left == '0) begin
          state_d = ST_DONE;
        end else begin
          frames_d = frames_left - 16'd1;
          if (state == ST_WAIT) begin
            if (gap_cnt != '0) begin
              gap_d = gap_cnt - 8'd1;
            end else if ((active_count < MAX_ACT) && (|idle)) begin
              state_d = ST_PICK;
            end
          end else if (state == ST_PICK) begin
            if (|idle) begin
              sel_d   = next_idle(lfsr[SEL_W-1:0], idle);
              hold_d  = '0;
              state_d = ST_ISSUE;
            end else begin
              gap_d   = '0;
              state_d = ST_WAIT;
            end
          end else begin
            if (!idle[sel]) begin
              spawn_d = (spawn_count == 8'hFF) ? spawn_count : spawn_count + 8'd1;
              gap_d   = GAP_INIT;
              state_d = ST_WAIT;
            end else if (hold_cnt == HOLD_LAST) begin
              gap_d   = GAP_INIT;
              state_d = ST_WAIT;
            end else begin
              hold_d = hold_cnt + 8'd1;
            end
          end
        end
      end
      ST_DONE: begin
        if (!run_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start = '0;
    if ((state == ST_ISSUE) && !pause) start[sel] = 1'b1;
    game_over = (state == ST_DONE);
  end

endmodule
